// File: rtl/audio_pkg.sv
// audio_pkg: shared audio definitions for the receive and speaker-side blocks.
package audio_pkg;
   typedef enum logic [1:0] {WAIT_FRAME, SKIP, SHIFT, HOLD} rx_state_t;
   localparam int SKIP_BITS = 1;
   typedef enum logic [1:0] {SPK_IDLE, SPK_LOAD, SPK_SHIFT} spk_state_t;
   localparam int SPK_FIFO_DEPTH = 4;
endpackage

// File: rtl/sig_sync_edge.sv
// sig_sync_edge: multi-flop synchronizer with one-cycle rise/fall strobes.
module sig_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end
   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;
endmodule

// File: rtl/audio_serial_rx.sv
// audio_serial_rx: I2S stereo receiver with valid/ready output and sticky overrun.
// Optional mono_out (left+right)/2 when AUDIO_RX_MONO_SUM_EN is defined.
module audio_serial_rx
   import audio_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk_in,
   input  logic              lclk_in,
   input  logic              sdata_in,
   output logic [DATA_W-1:0] left_out,
   output logic [DATA_W-1:0] right_out,
`ifdef AUDIO_RX_MONO_SUM_EN
   output logic [DATA_W-1:0] mono_out,
`endif
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overrun
);
   localparam int CW = $clog2(DATA_W + 1);
   logic sclk_lvl, sclk_rise, sclk_fall, lclk_lvl, lclk_rise, lclk_fall;
   logic sdata, sdata_rise, sdata_fall;
   logic unused_edges;
   sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst_n(rst_n), .d(sclk_in), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
   sig_sync_edge #(.STAGES(SYNC_STAGES)) u_lclk (.clk(clk), .rst_n(rst_n), .d(lclk_in), .level(lclk_lvl), .rise(lclk_rise), .fall(lclk_fall));
   sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sdat (.clk(clk), .rst_n(rst_n), .d(sdata_in), .level(sdata), .rise(sdata_rise), .fall(sdata_fall));
   assign unused_edges = ^{sclk_lvl, sclk_fall, lclk_lvl, sdata_rise, sdata_fall};
   rx_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] word_q, left_cap_q, right_cap_q, bit_mask;
   logic              have_left_q, pair_done_q, lclk_edge, latch;
   assign lclk_edge = lclk_rise | lclk_fall;
   assign latch     = lclk_edge && (state_q == SHIFT || state_q == HOLD);
   assign bit_mask  = {1'b1, {(DATA_W-1){1'b0}}} >> cnt_q;
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_FRAME: state_d = lclk_fall ? SKIP : WAIT_FRAME;
         SKIP:       state_d = (sclk_rise && cnt_q == CW'(SKIP_BITS - 1)) ? SHIFT : SKIP;
         SHIFT:      state_d = lclk_edge ? SKIP : (sclk_rise && cnt_q == CW'(DATA_W - 1)) ? HOLD : SHIFT;
         HOLD:       state_d = lclk_edge ? SKIP : HOLD;
         default:    state_d = WAIT_FRAME;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= WAIT_FRAME;
         cnt_q       <= '0;
         word_q      <= '0;
         left_cap_q  <= '0;
         right_cap_q <= '0;
         have_left_q <= 1'b0;
         pair_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pair_done_q <= latch && lclk_fall && have_left_q;
         if (state_d == SKIP && state_q != SKIP) begin
            cnt_q  <= '0;
            word_q <= '0;
         end else if (sclk_rise && state_q == SKIP) begin
            cnt_q <= (state_d == SHIFT) ? '0 : cnt_q + 1'b1;
         end else if (sclk_rise && state_q == SHIFT) begin
            word_q <= sdata ? (word_q | bit_mask) : word_q;
            cnt_q  <= cnt_q + 1'b1;
         end
         // A falling lclk closes the right word, a rising one the left word.
         if (latch && lclk_fall) right_cap_q <= word_q;
         if (latch && lclk_rise) begin
            left_cap_q  <= word_q;
            have_left_q <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_out     <= '0;
         right_out    <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (pair_done_q) begin
         left_out     <= left_cap_q;
         right_out    <= right_cap_q;
         sample_valid <= 1'b1;
         overrun      <= overrun | (sample_valid & ~sample_ready);
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end
`ifdef AUDIO_RX_MONO_SUM_EN
   logic [DATA_W:0] mono_sum;
   assign mono_sum = {left_cap_q[DATA_W-1], left_cap_q} + {right_cap_q[DATA_W-1], right_cap_q};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mono_out <= '0;
      else if (pair_done_q) mono_out <= mono_sum[DATA_W:1];
   end
`endif
endmodule

// File: tb/tb_audio_serial_rx.sv
// tb_audio_serial_rx: directed I2S frames with hand-computed expected samples.
module tb_audio_serial_rx;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        sclk_in = 1'b0, lclk_in = 1'b1, sdata_in = 1'b0, sample_ready = 1'b0;
   logic [15:0] left_out, right_out;
   logic        sample_valid, overrun;
   int          n_cmp = 0, n_bad = 0, pulses = 0, base;
   logic [15:0] cap_l = '0, cap_r = '0;
`ifdef AUDIO_RX_MONO_SUM_EN
   logic [15:0] mono_out, cap_m = '0;
`endif

   audio_serial_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .lclk_in(lclk_in), .sdata_in(sdata_in),
      .left_out(left_out), .right_out(right_out),
`ifdef AUDIO_RX_MONO_SUM_EN
      .mono_out(mono_out),
`endif
      .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun));

   always #5 clk = ~clk;

   always @(negedge clk) if (sample_valid) begin
      pulses <= pulses + 1;
      cap_l  <= left_out;
      cap_r  <= right_out;
`ifdef AUDIO_RX_MONO_SUM_EN
      cap_m  <= mono_out;
`endif
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      sclk_in = 1'b0; sdata_in = b; hold(8);
      sclk_in = 1'b1; hold(8);
   endtask

   // lclk change, one skipped I2S delay bit, then n bits MSB first.
   task automatic send_word(input logic ch, input logic [31:0] v, input int n);
      lclk_in = ch;
      send_bit(1'b0);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
      send_word(1'b0, l, n);
      send_word(1'b1, r, n);
   endtask

   task automatic close_frame();
      lclk_in = 1'b0; hold(10);
   endtask

   task automatic test_reset();
      hold(3);
      n_cmp++; if (left_out !== 16'h0) begin n_bad++; $display("FAIL reset_left got %h want 0000", left_out); end
      n_cmp++; if (right_out !== 16'h0) begin n_bad++; $display("FAIL reset_right got %h want 0000", right_out); end
      n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", sample_valid); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
`ifdef AUDIO_RX_MONO_SUM_EN
      n_cmp++; if (mono_out !== 16'h0) begin n_bad++; $display("FAIL reset_mono got %h want 0000", mono_out); end
`endif
      rst_n = 1'b1; hold(3);
   endtask

   task automatic test_basic();
      sample_ready = 1'b1; base = pulses;
      send_frame(32'h1234, 32'hABCD, 16);
      n_cmp++; if (pulses - base !== 0) begin n_bad++; $display("FAIL basic_no_early got %0d pulses want 0", pulses - base); end
      send_frame(32'h1234, 32'hABCD, 16);
      close_frame();
      n_cmp++; if (pulses - base !== 2) begin n_bad++; $display("FAIL basic_pulses got %0d want 2", pulses - base); end
      n_cmp++; if (cap_l !== 16'h1234) begin n_bad++; $display("FAIL basic_left got %h want 1234", cap_l); end
      n_cmp++; if (cap_r !== 16'hABCD) begin n_bad++; $display("FAIL basic_right got %h want abcd", cap_r); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL basic_overrun got %b want 0", overrun); end
      n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_clear got %b want 0", sample_valid); end
   endtask

   task automatic test_short_word();
      base = pulses;
      send_word(1'b0, 32'hFFF, 12);
      send_word(1'b1, 32'h5A5A, 16);
      close_frame();
      n_cmp++; if (pulses - base !== 1) begin n_bad++; $display("FAIL short_pulses got %0d want 1", pulses - base); end
      n_cmp++; if (cap_l !== 16'hFFF0) begin n_bad++; $display("FAIL short_left got %h want fff0", cap_l); end
      n_cmp++; if (cap_r !== 16'h5A5A) begin n_bad++; $display("FAIL short_right got %h want 5a5a", cap_r); end
   endtask

   task automatic test_long_word();
      base = pulses;
      send_frame(32'h8001FF, 32'h7FFE55, 24);
      close_frame();
      n_cmp++; if (pulses - base !== 1) begin n_bad++; $display("FAIL long_pulses got %0d want 1", pulses - base); end
      n_cmp++; if (cap_l !== 16'h8001) begin n_bad++; $display("FAIL long_left got %h want 8001", cap_l); end
      n_cmp++; if (cap_r !== 16'h7FFE) begin n_bad++; $display("FAIL long_right got %h want 7ffe", cap_r); end
   endtask

   task automatic test_overrun();
      sample_ready = 1'b0;
      send_frame(32'h0001, 32'h0002, 16);
      send_frame(32'h0003, 32'h0004, 16);
      close_frame();
      n_cmp++; if (left_out !== 16'h0003) begin n_bad++; $display("FAIL ovr_left got %h want 0003", left_out); end
      n_cmp++; if (right_out !== 16'h0004) begin n_bad++; $display("FAIL ovr_right got %h want 0004", right_out); end
      n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid got %b want 1", sample_valid); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", overrun); end
      sample_ready = 1'b1; hold(2);
      n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_handshake got %b want 0", sample_valid); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", overrun); end
   endtask

   task automatic test_mid_reset();
      sample_ready = 1'b1;
      lclk_in = 1'b0; send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      rst_n = 1'b0; hold(1);
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL midrst_overrun got %b want 0", overrun); end
      n_cmp++; if (left_out !== 16'h0) begin n_bad++; $display("FAIL midrst_left got %h want 0000", left_out); end
      base = pulses;
      for (int i = 0; i < 11; i++) send_bit(1'b1);
      send_word(1'b1, 32'hBEEF, 16);
      lclk_in = 1'b0; send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) send_bit(1'b0);
      send_word(1'b1, 32'hCAFE, 16);
      close_frame();
      n_cmp++; if (pulses - base !== 0) begin n_bad++; $display("FAIL midrst_partial got %0d pulses want 0", pulses - base); end
      send_frame(32'h2468, 32'h1357, 16);
      close_frame();
      n_cmp++; if (pulses - base !== 1) begin n_bad++; $display("FAIL midrst_pulses got %0d want 1", pulses - base); end
      n_cmp++; if (cap_l !== 16'h2468) begin n_bad++; $display("FAIL midrst_left got %h want 2468", cap_l); end
      n_cmp++; if (cap_r !== 16'h1357) begin n_bad++; $display("FAIL midrst_right got %h want 1357", cap_r); end
   endtask

`ifdef AUDIO_RX_MONO_SUM_EN
   task automatic test_mono();
      send_frame(32'h7FFF, 32'h7FFF, 16);
      close_frame();
      n_cmp++; if (cap_m !== 16'h7FFF) begin n_bad++; $display("FAIL mono_pos got %h want 7fff", cap_m); end
      send_frame(32'h8000, 32'h0000, 16);
      close_frame();
      n_cmp++; if (cap_m !== 16'hC000) begin n_bad++; $display("FAIL mono_neg got %h want c000", cap_m); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_short_word();
      test_long_word();
      test_overrun();
      test_mid_reset();
`ifdef AUDIO_RX_MONO_SUM_EN
      test_mono();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
